// File: rtl/joy_db15_pkg.sv
// Shared types, decode-table bit indices and player-word field positions for the DB15 scan scheduler.
package joy_db15_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        PUBLISH,
        GAP
    } state_e;

    // Captured-frame bit index of each splitter input (active-low on the wire)
    localparam int IDX_P1_D     = 0;
    localparam int IDX_P1_C     = 1;
    localparam int IDX_P1_B     = 2;
    localparam int IDX_P1_A     = 3;
    localparam int IDX_P1_R     = 4;
    localparam int IDX_P1_L     = 5;
    localparam int IDX_P1_DN    = 6;
    localparam int IDX_P1_UP    = 7;
    localparam int IDX_P2_R     = 8;
    localparam int IDX_P2_L     = 9;
    localparam int IDX_P2_DN    = 10;
    localparam int IDX_P2_UP    = 11;
    localparam int IDX_P1_F     = 12;
    localparam int IDX_P1_E     = 13;
    localparam int IDX_P1_SEL   = 14;
    localparam int IDX_P1_START = 15;
    localparam int IDX_P2_F     = 16;
    localparam int IDX_P2_E     = 17;
    localparam int IDX_P2_SEL   = 18;
    localparam int IDX_P2_START = 19;
    localparam int IDX_P2_D     = 20;
    localparam int IDX_P2_C     = 21;
    localparam int IDX_P2_B     = 22;
    localparam int IDX_P2_A     = 23;

    localparam int W_RIGHT  = 0;
    localparam int W_LEFT   = 1;
    localparam int W_DOWN   = 2;
    localparam int W_UP     = 3;
    localparam int W_A      = 4;
    localparam int W_B      = 5;
    localparam int W_C      = 6;
    localparam int W_D      = 7;
    localparam int W_E      = 8;
    localparam int W_F      = 9;
    localparam int W_START  = 10;
    localparam int W_SELECT = 11;

    function automatic logic [15:0] decode_p1(input logic [23:0] f);
        logic [15:0] w;
        w           = '0;
        w[W_RIGHT]  = ~f[IDX_P1_R];
        w[W_LEFT]   = ~f[IDX_P1_L];
        w[W_DOWN]   = ~f[IDX_P1_DN];
        w[W_UP]     = ~f[IDX_P1_UP];
        w[W_A]      = ~f[IDX_P1_A];
        w[W_B]      = ~f[IDX_P1_B];
        w[W_C]      = ~f[IDX_P1_C];
        w[W_D]      = ~f[IDX_P1_D];
        w[W_E]      = ~f[IDX_P1_E];
        w[W_F]      = ~f[IDX_P1_F];
        w[W_START]  = ~f[IDX_P1_START];
        w[W_SELECT] = ~f[IDX_P1_SEL];
        return w;
    endfunction

    function automatic logic [15:0] decode_p2(input logic [23:0] f);
        logic [15:0] w;
        w           = '0;
        w[W_RIGHT]  = ~f[IDX_P2_R];
        w[W_LEFT]   = ~f[IDX_P2_L];
        w[W_DOWN]   = ~f[IDX_P2_DN];
        w[W_UP]     = ~f[IDX_P2_UP];
        w[W_A]      = ~f[IDX_P2_A];
        w[W_B]      = ~f[IDX_P2_B];
        w[W_C]      = ~f[IDX_P2_C];
        w[W_D]      = ~f[IDX_P2_D];
        w[W_E]      = ~f[IDX_P2_E];
        w[W_F]      = ~f[IDX_P2_F];
        w[W_START]  = ~f[IDX_P2_START];
        w[W_SELECT] = ~f[IDX_P2_SEL];
        return w;
    endfunction

endpackage

// File: rtl/joy_db15_clk_div.sv
// JOY_CLK half-period tick generator: counts 0..CLK_DIV-1 while enabled, tick on the last count.
module joy_db15_clk_div #(
    parameter int CLK_DIV = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/joy_db15_scan_sched.sv
// DB15 splitter scan scheduler: LOAD/SHIFT sequencing, frame capture and atomic player-word publish.
// Optional macro JOY_DB15_DEBOUNCE_EN: publish only when a frame matches the previous captured frame.
module joy_db15_scan_sched
    import joy_db15_pkg::*;
#(
    parameter int CLK_DIV     = 128,
    parameter int SKIP_BITS   = 1,
    parameter int NUM_BITS    = 24,
    parameter int GAP_PERIODS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                auto_en,
    input  logic                scan_req,
    output logic                scan_busy,
    output logic                JOY_CLK,
    output logic                JOY_LOAD,
    input  logic                JOY_DATA,
    output logic [NUM_BITS-1:0] raw_frame,
    output logic                frame_valid,
    output logic [15:0]         joystick1,
    output logic [15:0]         joystick2
);
    localparam int CW = 16;

    state_e              state_q, state_d;
    logic                jclk_q, jclk_d, jload_q, jload_d, busy_q, busy_d, fv_q, fv_d;
    logic [NUM_BITS-1:0] buf_q, buf_d, raw_q, raw_d, shift_val;
    logic [15:0]         j1_q, j1_d, j2_q, j2_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          sync_q;
    logic [23:0]         dec_in;
    logic                tick, div_en, div_clr, publish;
`ifdef JOY_DB15_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
`endif

    assign div_en  = (state_q == LOAD) || (state_q == SHIFT) || (state_q == GAP);
    assign div_clr = (state_q == IDLE) || (state_q == PUBLISH);

    joy_db15_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .reset(reset),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick)
    );

    // New bits enter at the top so the first captured bit ends up at index 0
    assign shift_val = {sync_q[1], buf_q[NUM_BITS-1:1]};

    always_comb begin
        dec_in = '1;
        for (int i = 0; i < 24; i++)
            if (i < NUM_BITS) dec_in[i] = shift_val[i];
    end

`ifdef JOY_DB15_DEBOUNCE_EN
    assign publish = prev_vld_q && (shift_val == prev_q);
`else
    assign publish = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        jclk_d  = jclk_q;
        jload_d = jload_q;
        busy_d  = busy_q;
        fv_d    = 1'b0;
        buf_d   = buf_q;
        raw_d   = raw_q;
        j1_d    = j1_q;
        j2_d    = j2_q;
        cnt_d   = cnt_q;
`ifdef JOY_DB15_DEBOUNCE_EN
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
`endif
        case (state_q)
            IDLE: begin
                jclk_d  = 1'b0;
                jload_d = 1'b1;
                if (auto_en || scan_req) begin
                    state_d = LOAD;
                    jload_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (tick) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = SHIFT;
                        jload_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    jclk_d = ~jclk_q;
                    if (jclk_q) begin
                        if (cnt_q >= CW'(SKIP_BITS))
                            buf_d = shift_val;
                        if (cnt_q == CW'(SKIP_BITS + NUM_BITS - 1)) begin
                            state_d = PUBLISH;
                            cnt_d   = '0;
                            if (publish) begin
                                raw_d = shift_val;
                                j1_d  = decode_p1(dec_in);
                                j2_d  = decode_p2(dec_in);
                                fv_d  = 1'b1;
                            end
`ifdef JOY_DB15_DEBOUNCE_EN
                            prev_d     = shift_val;
                            prev_vld_d = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            PUBLISH: begin
                cnt_d = '0;
                if (!auto_en) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (GAP_PERIODS == 0) begin
                    state_d = LOAD;
                    jload_d = 1'b0;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_q == CW'(2 * GAP_PERIODS - 1)) begin
                        cnt_d = '0;
                        if (auto_en) begin
                            state_d = LOAD;
                            jload_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                jload_d = 1'b1;
                jclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            jclk_q  <= 1'b0;
            jload_q <= 1'b1;
            busy_q  <= 1'b0;
            fv_q    <= 1'b0;
            buf_q   <= '1;
            raw_q   <= '1;
            j1_q    <= '0;
            j2_q    <= '0;
            cnt_q   <= '0;
            sync_q  <= 2'b11;
`ifdef JOY_DB15_DEBOUNCE_EN
            prev_q     <= '1;
            prev_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            jclk_q  <= jclk_d;
            jload_q <= jload_d;
            busy_q  <= busy_d;
            fv_q    <= fv_d;
            buf_q   <= buf_d;
            raw_q   <= raw_d;
            j1_q    <= j1_d;
            j2_q    <= j2_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], JOY_DATA};
`ifdef JOY_DB15_DEBOUNCE_EN
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
`endif
        end
    end

    assign scan_busy   = busy_q;
    assign JOY_CLK     = jclk_q;
    assign JOY_LOAD    = jload_q;
    assign frame_valid = fv_q;
    assign raw_frame   = raw_q;
    assign joystick1   = j1_q;
    assign joystick2   = j2_q;
endmodule

// File: tb/tb_joy_db15_scan_sched.sv
// Scoreboarded bench for joy_db15_scan_sched with a behavioural DB15 splitter shift-chain model.
module tb_joy_db15_scan_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        auto_en = 1'b0;
    logic        scan_req = 1'b0;
    logic        scan_busy, JOY_CLK, JOY_LOAD, JOY_DATA, frame_valid;
    logic [23:0] raw_frame;
    logic [15:0] joystick1, joystick2;

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    typedef struct {
        logic [23:0] raw;
        logic [15:0] j1;
        logic [15:0] j2;
    } exp_t;
    exp_t sb[$];

    joy_db15_scan_sched dut (
        .clk        (clk),
        .reset      (reset),
        .auto_en    (auto_en),
        .scan_req   (scan_req),
        .scan_busy  (scan_busy),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .raw_frame  (raw_frame),
        .frame_valid(frame_valid),
        .joystick1  (joystick1),
        .joystick2  (joystick2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Splitter: one leading dummy bit (discarded by the scheduler), then pattern bit 0 upward
    logic [23:0] pat = '1;
    logic [24:0] sh  = '1;
    logic        jc_prev = 1'b0;
    always @(posedge clk) begin
        if (!JOY_LOAD)
            sh <= {pat, 1'b1};
        else if (jc_prev && !JOY_CLK)
            sh <= {1'b1, sh[24:1]};
        jc_prev <= JOY_CLK;
    end
    assign JOY_DATA = sh[0];

    // Player/bit for each captured index: value = player*16 + word bit
    function automatic int map_idx(input int i);
        case (i)
            0: return 16+7;   1: return 16+6;   2: return 16+5;   3: return 16+4;
            4: return 16+0;   5: return 16+1;   6: return 16+2;   7: return 16+3;
            8: return 32+0;   9: return 32+1;  10: return 32+2;  11: return 32+3;
           12: return 16+9;  13: return 16+8;  14: return 16+11; 15: return 16+10;
           16: return 32+9;  17: return 32+8;  18: return 32+11; 19: return 32+10;
           20: return 32+7;  21: return 32+6;  22: return 32+5;  default: return 32+4;
        endcase
    endfunction

    function automatic exp_t mk(input logic [23:0] p);
        exp_t e;
        int   m;
        e.raw = p;
        e.j1  = '0;
        e.j2  = '0;
        for (int i = 0; i < 24; i++) begin
            m = map_idx(i);
            if (!p[i]) begin
                if (m >= 32) e.j2[m-32] = 1'b1;
                else         e.j1[m-16] = 1'b1;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (frame_valid) begin
            vecs++;
            if (sb.size() == 0) begin
                miss++;
                $display("FAIL unexpected_frame_valid raw=%h j1=%h j2=%h required none", raw_frame, joystick1, joystick2);
            end else begin
                e = sb.pop_front();
                if (raw_frame !== e.raw || joystick1 !== e.j1 || joystick2 !== e.j2) begin
                    miss++;
                    $display("FAIL frame got raw=%h j1=%h j2=%h required raw=%h j1=%h j2=%h",
                             raw_frame, joystick1, joystick2, e.raw, e.j1, e.j2);
                end
            end
        end
    end

    task automatic wait_fv(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if ({JOY_CLK, JOY_LOAD, scan_busy, frame_valid, raw_frame, joystick1, joystick2} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 16'h0, 16'h0}) begin
            miss++;
            $display("FAIL reset_values clk=%b load=%b busy=%b fv=%b raw=%h j1=%h j2=%h required 0 1 0 0 ffffff 0000 0000",
                     JOY_CLK, JOY_LOAD, scan_busy, frame_valid, raw_frame, joystick1, joystick2);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        vecs++;
        if (scan_busy !== 1'b0 || JOY_LOAD !== 1'b1) begin
            miss++;
            $display("FAIL idle_after_reset busy=%b load=%b required busy=0 load=1", scan_busy, JOY_LOAD);
        end
    endtask

    task automatic test_auto_ones();
        int a1, a2;
        pat = '1;
        sb.push_back(mk(pat));
        sb.push_back(mk(pat));
        auto_en = 1'b1;
        wait_fv(20000, a1);
        vecs++;
        if (a1 < 0) begin
            miss++;
            $display("FAIL auto_first_frame timeout required frame_valid");
        end
        wait_fv(8000, a2);
        vecs++;
        if (a2 < 0 || a1 < 0 || (a2 - a1) != 6913) begin
            miss++;
            $display("FAIL auto_period got %0d required 6913", a2 - a1);
        end
    endtask

    task automatic test_p1_a();
        int a;
        pat = 24'hFFFFF7;
        sb.push_back(mk(pat));
        wait_fv(8000, a);
        vecs++;
        if (a < 0 || joystick1 !== 16'h0010 || joystick2 !== 16'h0000 || raw_frame !== 24'hFFFFF7) begin
            miss++;
            $display("FAIL p1_a got j1=%h j2=%h raw=%h required 0010 0000 fffff7", joystick1, joystick2, raw_frame);
        end
    endtask

    task automatic test_auto_stop_p2();
        int a;
        pat = 24'hF7FEFF;
        sb.push_back(mk(pat));
        repeat (2000) @(negedge clk);
        auto_en = 1'b0;
        wait_fv(8000, a);
        vecs++;
        if (a < 0 || joystick2 !== 16'h0401 || joystick1 !== 16'h0000) begin
            miss++;
            $display("FAIL p2_start_right got j1=%h j2=%h required 0000 0401", joystick1, joystick2);
        end
        repeat (300) @(negedge clk);
        vecs++;
        if ({scan_busy, JOY_LOAD, JOY_CLK} !== 3'b010) begin
            miss++;
            $display("FAIL auto_stop_idle got busy/load/clk=%b required 010", {scan_busy, JOY_LOAD, JOY_CLK});
        end
    endtask

    task automatic test_manual_drop();
        int a;
        pat = 24'($urandom) & 24'hFF7FFF;
        sb.push_back(mk(pat));
        pulse_req();
        vecs++;
        if (JOY_LOAD !== 1'b0 || scan_busy !== 1'b1) begin
            miss++;
            $display("FAIL manual_start got load=%b busy=%b required 0 1", JOY_LOAD, scan_busy);
        end
        repeat (20) @(negedge clk);
        pulse_req();
        wait_fv(8000, a);
        vecs++;
        if (a < 0) begin
            miss++;
            $display("FAIL manual_frame timeout required frame_valid");
        end
        repeat (3) @(negedge clk);
        vecs++;
        if ({scan_busy, JOY_LOAD, JOY_CLK} !== 3'b010) begin
            miss++;
            $display("FAIL manual_idle got busy/load/clk=%b required 010", {scan_busy, JOY_LOAD, JOY_CLK});
        end
        repeat (300) @(negedge clk);
        vecs++;
        if (scan_busy !== 1'b0) begin
            miss++;
            $display("FAIL dropped_req got busy=%b required 0", scan_busy);
        end
    endtask

    task automatic test_reset_mid();
        int  falls, a;
        logic prev;
        pat = 24'h123456;
        pulse_req();
        falls = 0;
        prev  = JOY_CLK;
        for (int i = 0; i < 8000 && falls < 11; i++) begin
            @(negedge clk);
            if (prev && !JOY_CLK) falls++;
            prev = JOY_CLK;
        end
        vecs++;
        if (falls < 11) begin
            miss++;
            $display("FAIL reach_bit10 got %0d falls required 11", falls);
        end
        reset = 1'b1;
        @(negedge clk);
        vecs++;
        if ({JOY_CLK, JOY_LOAD, scan_busy, frame_valid, raw_frame, joystick1, joystick2} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 16'h0, 16'h0}) begin
            miss++;
            $display("FAIL reset_mid clk=%b load=%b busy=%b fv=%b raw=%h j1=%h j2=%h required 0 1 0 0 ffffff 0000 0000",
                     JOY_CLK, JOY_LOAD, scan_busy, frame_valid, raw_frame, joystick1, joystick2);
        end
        reset = 1'b0;
        pat = 24'hA5C3E1;
        sb.push_back(mk(pat));
        pulse_req();
        wait_fv(8000, a);
        vecs++;
        if (a < 0 || raw_frame !== 24'hA5C3E1) begin
            miss++;
            $display("FAIL post_reset_frame got raw=%h required a5c3e1", raw_frame);
        end
    endtask

`ifdef JOY_DB15_DEBOUNCE_EN
    task automatic scan_to_idle();
        pulse_req();
        for (int i = 0; i < 8000 && scan_busy; i++) @(negedge clk);
        vecs++;
        if (scan_busy !== 1'b0) begin
            miss++;
            $display("FAIL debounce_scan timeout busy=%b required 0", scan_busy);
        end
    endtask

    task automatic test_debounce();
        int a;
        pat = 24'hFFFF00;
        scan_to_idle();
        pat = 24'hFF00FF;
        scan_to_idle();
        sb.push_back(mk(pat));
        pulse_req();
        wait_fv(8000, a);
        vecs++;
        if (a < 0 || raw_frame !== 24'hFF00FF) begin
            miss++;
            $display("FAIL debounce_publish got raw=%h required ff00ff", raw_frame);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef JOY_DB15_DEBOUNCE_EN
        test_debounce();
`else
        test_auto_ones();
        test_p1_a();
        test_auto_stop_p2();
        test_manual_drop();
        test_reset_mid();
`endif
        repeat (5) @(negedge clk);
        vecs++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
